inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_if.sv | 20 ++
 rtl/inst_buffer.sv | 59 +++++
 tb/tb_inst_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch-to-decode bundle for the instruction buffer.
interface inst_buffer_if #(parameter int N = 3, parameter int W = 129, parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH + 1);
  logic            i_squash;
  logic [N-1:0]    i_if_valid;
  logic [N*W-1:0]  i_if_data;
  logic            o_if_ready;
  logic            i_id_stall;
  logic [N-1:0]    o_id_valid;
  logic [N*W-1:0]  o_id_data;
  logic [CW-1:0]   o_count;
  modport slave (
    input  i_squash, i_if_valid, i_if_data, i_id_stall,
    output o_if_ready, o_id_valid, o_id_data, o_count
  );
  modport master (
    output i_squash, i_if_valid, i_if_data, i_id_stall,
    input  o_if_ready, o_id_valid, o_id_data, o_count
  );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer: N-wide circular instruction FIFO between fetch and decode.
module inst_buffer #(
  parameter int N     = 3,
  parameter int DEPTH = 16,
  parameter int W     = 129
) (
  input logic          clk,
  input logic          rst_n,
  inst_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_enq, w_acc, w_deq;
  logic          w_run, w_ready;
  // only the unbroken run of valids from lane 0 is taken
  always_comb begin
    w_enq = '0;
    w_run = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_run = w_run & bus.i_if_valid[i];
      w_enq = w_enq + CW'(w_run);
    end
  end
  assign w_ready = r_count <= CW'(DEPTH - N);
  assign w_acc   = w_ready ? w_enq : '0;
  assign w_deq   = bus.i_id_stall ? '0 : (r_count < CW'(N) ? r_count : CW'(N));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.i_squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_acc);
      r_count <= r_count + w_acc - w_deq;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (!bus.i_squash && CW'(i) < w_acc)
        r_mem[r_tail + PW'(i)] <= bus.i_if_data[i*W +: W];
  end
  always_comb begin
    bus.o_id_valid = '0;
    bus.o_id_data  = '0;
    for (int i = 0; i < N; i++) begin
      bus.o_id_valid[i]        = CW'(i) < r_count;
      bus.o_id_data[i*W +: W]  = r_mem[r_head + PW'(i)];
    end
  end
  assign bus.o_if_ready = w_ready;
  assign bus.o_count    = r_count;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for inst_buffer with N=3, DEPTH=8.
module tb_inst_buffer;
  localparam int N = 3, DEPTH = 8, W = 129;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  logic [W-1:0] q[$];
  logic [31:0] pc = '0;
  always #5 clk = ~clk;
  inst_buffer_if #(.N(N), .W(W), .DEPTH(DEPTH)) bus();
  inst_buffer #(.N(N), .DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] p);
    logic [31:0] inst, tgt;
    inst = $urandom();
    tgt  = $urandom();
    return {tgt, inst[0], p + 32'd4, p, inst};
  endfunction

  task automatic check_all();
    logic [N-1:0] ev;
    int sz;
    sz = q.size();
    ev = '0;
    for (int i = 0; i < N; i++) ev[i] = i < sz;
    chk("count", W'(bus.o_count), W'(sz));
    chk("if_ready", W'(bus.o_if_ready), W'(sz <= DEPTH - N));
    chk("id_valid", W'(bus.o_id_valid), W'(ev));
    for (int i = 0; i < N && i < sz; i++)
      chk($sformatf("lane%0d", i), bus.o_id_data[i*W +: W], q[i]);
  endtask

  task automatic step(input logic sq, input logic [N-1:0] v, input logic st);
    logic [W-1:0] d[N];
    int sz, enq, acc, deq;
    for (int i = 0; i < N; i++) begin
      d[i] = mk(pc);
      pc = pc + 32'd4;
    end
    bus.i_squash = sq;
    bus.i_if_valid = v;
    bus.i_id_stall = st;
    for (int i = 0; i < N; i++) bus.i_if_data[i*W +: W] = d[i];
    sz = q.size();
    enq = 0;
    for (int i = 0; i < N; i++) if (v[i] && enq == i) enq++;
    acc = (sz <= DEPTH - N) ? enq : 0;
    deq = st ? 0 : (sz < N ? sz : N);
    if (sq) q.delete();
    else begin
      repeat (deq) void'(q.pop_front());
      for (int i = 0; i < acc; i++) q.push_back(d[i]);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.i_squash = 1'b0;
    bus.i_if_valid = '0;
    bus.i_if_data = '0;
    bus.i_id_stall = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    pc = 32'h0;
    step(0, 3'b111, 1);
    for (int i = 0; i < N; i++) chk("pc", W'(bus.o_id_data[i*W+32 +: 32]), W'(i * 4));
    step(0, 3'b111, 1);
    step(0, 3'b111, 1);
    chk("full_hold", W'(bus.o_count), W'(6));
    step(1, 3'b000, 1);
    step(0, 3'b111, 1);
    step(0, 3'b011, 1);
    step(0, 3'b111, 1);
    chk("fill8", W'(bus.o_count), W'(8));
    step(1, 3'b000, 1);
    step(0, 3'b111, 1);
    step(0, 3'b111, 1);
    step(0, 3'b000, 0);
    step(0, 3'b000, 0);
    step(0, 3'b111, 1);
    step(0, 3'b001, 1);
    step(0, 3'b000, 0);
    chk("wrap", W'(bus.o_count), W'(1));
    step(0, 3'b111, 1);
    step(0, 3'b011, 0);
    step(0, 3'b101, 1);
    step(0, 3'b111, 1);
    step(1, 3'b111, 0);
    for (int k = 0; k < 300; k++) begin
      if (k == 150) mid_reset();
      step($urandom_range(0, 30) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
